sop_truth_sweeper: RTL

//  Parametrised successor to the fixed 3-input AND/OR gate circuits.

---
 rtl/sop_sweeper_pkg.sv | 15 +
 rtl/sop_eval.sv | 24 ++
 rtl/sop_truth_sweeper.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sop_sweeper_pkg.sv
// Shared types and helpers for the sum-of-products truth-table sweeper.
// The optional minterm counter is enabled in the top by SOP_MINTERM_COUNT_EN.
package sop_sweeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/sop_eval.sv
// Combinational sum-of-products evaluator: Z = OR over terms of AND of masked inputs.
// A term whose mask is all zero contributes 0 rather than a constant 1.
module sop_eval #(
  parameter int N_IN    = 3,
  parameter int N_TERMS = 3
) (
  input  logic [N_IN-1:0]         x,
  input  logic [N_TERMS*N_IN-1:0] mask,
  output logic                    z
);

  logic [N_IN-1:0] term_m;

  // OR together every product term that has at least one selected input
  always_comb begin
    z      = 1'b0;
    term_m = {N_IN{1'b0}};
    for (int t = 0; t < N_TERMS; t++) begin
      term_m = mask[t*N_IN +: N_IN];
      z      = z | ((term_m != {N_IN{1'b0}}) && ((x & term_m) == term_m));
    end
  end

endmodule

// File: rtl/sop_truth_sweeper.sv
// Programmable SOP function with a registered live path and a full truth-table sweep.
// Define SOP_MINTERM_COUNT_EN to add the minterm_count output.
module sop_truth_sweeper
  import sop_sweeper_pkg::*;
#(
  parameter  int N_IN    = 3,
  parameter  int N_TERMS = 3,
  localparam int TT_W    = tt_width(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_TERMS*N_IN-1:0] term_mask,
  input  logic [N_IN-1:0]         x_in,
  output logic                    z_live,
  output logic                    busy,
  output logic                    done,
`ifdef SOP_MINTERM_COUNT_EN
  output logic [N_IN:0]           minterm_count,
`endif
  output logic [TT_W-1:0]         truth_table
);

  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(TT_W - 1);
  localparam logic [N_IN:0] IDX_ONE  = (N_IN+1)'(1);

  state_e                    state_q, state_d;
  logic [N_IN:0]             idx_q, idx_d;
  logic [N_TERMS*N_IN-1:0]   mask_q, mask_d;
  logic [TT_W-1:0]           tt_q, tt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      z_live_q, z_live_d;
  logic [N_IN:0]             cnt_q, cnt_d;
  logic                      z_live_s;
  logic                      z_sweep_s;

  sop_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) u_eval_live (
    .x    (x_in),
    .mask (term_mask),
    .z    (z_live_s)
  );

  sop_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) u_eval_sweep (
    .x    (idx_q[N_IN-1:0]),
    .mask (mask_q),
    .z    (z_sweep_s)
  );

  // Sweep FSM, table fill and output next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    tt_d     = tt_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    z_live_d = z_live_s;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          mask_d  = term_mask;
          tt_d    = {TT_W{1'b0}};
          cnt_d   = {(N_IN+1){1'b0}};
          idx_d   = {(N_IN+1){1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        tt_d[idx_q[N_IN-1:0]] = z_sweep_s;
        if (z_sweep_s) begin
          cnt_d = cnt_q + IDX_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        idx_d = idx_q + IDX_ONE;
        // Final write lands at the same edge done rises, so idx stops at 2^N_IN
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= {(N_IN+1){1'b0}};
      mask_q   <= {(N_TERMS*N_IN){1'b0}};
      tt_q     <= {TT_W{1'b0}};
      cnt_q    <= {(N_IN+1){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_live_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      tt_q     <= tt_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      z_live_q <= z_live_d;
    end
  end

  assign z_live      = z_live_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
`ifdef SOP_MINTERM_COUNT_EN
  assign minterm_count = cnt_q;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^cnt_q;
`endif

endmodule
